// File: rtl/colorizer_palette_ctrl.sv
// Palette owner for the VGA colorizer: shadow writes, vblank-synchronised commit to active.
// Optional blink of icon entries 5..7 when COLORIZER_BLINK_EN is defined.
module colorizer_palette_ctrl #(
  parameter int NUM_ENTRIES  = 8,
  parameter int COLOR_W      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [2:0]                     wr_addr,
  input  logic [COLOR_W-1:0]             wr_data,
  input  logic                           commit_req,
  input  logic                           vblank,
  output logic [NUM_ENTRIES*COLOR_W-1:0] palette,
  output logic                           armed,
  output logic                           commit_done
);

  // state  | meaning
  // IDLE   | no commit pending, writes accepted
  // ARMED  | commit requested, waiting for vblank
  // COMMIT | one cycle: active <= shadow, writes stalled
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [NUM_ENTRIES-1:0][COLOR_W-1:0] pal_t;

  localparam pal_t DEFAULTS = {12'h0F0, 12'h0F0, 12'h0F0, 12'h000,
                               12'hF0F, 12'hF00, 12'h000, 12'hFFF};

  if (NUM_ENTRIES != 8 || COLOR_W != 12 || BLINK_FRAMES < 1) begin : g_param_check
    $error("colorizer_palette_ctrl: unsupported parameter set");
  end

  state_t state_q, state_d;
  pal_t   shadow, active, palette_view;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shadow  <= DEFAULTS;
      active  <= DEFAULTS;
    end else begin
      state_q <= state_d;
      if (wr_valid && wr_ready) shadow[wr_addr] <= wr_data;
      if (state_q == COMMIT) active <= shadow;
    end
  end

  // A request that arrives inside blanking skips ARMED so the commit lands next cycle.
  always_comb begin
    state_d     = state_q;
    wr_ready    = 1'b1;
    armed       = 1'b0;
    commit_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) state_d = vblank ? COMMIT : ARMED;
      end
      ARMED: begin
        armed = 1'b1;
        if (vblank) state_d = COMMIT;
      end
      COMMIT: begin
        wr_ready    = 1'b0;
        commit_done = 1'b1;
        state_d     = commit_req ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef COLORIZER_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             vblank_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      vblank_q    <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (vblank && !vblank_q) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Blinking icons show the background colour; the stored entries stay intact.
  always_comb begin
    palette_view = active;
    if (blink_phase) begin
      for (int i = 5; i < 8; i++) palette_view[i] = active[0];
    end
  end
`else
  assign palette_view = active;
`endif

  assign palette = palette_view;

endmodule

// File: doc/colorizer_palette_ctrl.md
Name: colorizer_palette_ctrl

Overview:
- Owns the colour palette used by the VGA colorizer stage.
- Accepts palette writes from the MIPS I/O bridge into shadow registers over a valid/ready handshake.
- Commits the shadow registers to the active palette only during vertical blanking, so no frame is drawn with a half-updated palette.
- Drives the flattened active palette straight into the colorizer's pixel-to-colour lookup.

Parameters:
- NUM_ENTRIES, 8, number of palette entries; fixed at 8, address width 3.
- COLOR_W, 12, bits per entry, {r[3:0],g[3:0],b[3:0]}.
- BLINK_FRAMES, 30, frames per blink half-period; used only with COLORIZER_BLINK_EN.

Ports:
- clock  input  1  pixel clock, 75 MHz
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  palette write request
- wr_ready  output  1  controller can accept a write this cycle
- wr_addr  input  3  entry index
- wr_data  input  12  entry colour, rrrrggggbbbb
- commit_req  input  1  single-cycle request to publish shadow to active
- vblank  input  1  level, high during vertical blanking, from the DTG
- palette  output  96  active palette, entry i at bits [12i+11:12i]
- armed  output  1  a commit is pending, waiting for vblank
- commit_done  output  1  one-cycle pulse, the commit is happening this cycle

Behaviour:
- Interface decision: one clock, `clock`; reset `reset` is synchronous and active-high.
- Entry map:
  - 0..3: world pixel codes 00..11.
  - 4: blanking colour.
  - 5..7: icon codes 01..11.
- Reset defaults, applied to both shadow and active copies: e0=FFF, e1=000, e2=F00, e3=F0F, e4=000, e5=0F0, e6=0F0, e7=0F0.
- Output reset values: wr_ready=1, armed=0, commit_done=0, palette=defaults.
- All outputs are registered or decoded from state. None depend combinationally on wr_valid, commit_req or vblank.
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready.
  - shadow[wr_addr] <= wr_data at that edge.
  - wr_ready is 0 only in the COMMIT state, and 1 otherwise.
  - Back-to-back writes are accepted at one per cycle.
  - A write never changes palette directly.
- FSM states: IDLE, ARMED, COMMIT.
  - IDLE: commit_req=1 -> ARMED.
  - ARMED: vblank=1 -> COMMIT, else stay. commit_req while ARMED is merged (no effect).
  - COMMIT lasts exactly one cycle:
    - commit_done=1 and wr_ready=0.
    - active <= shadow at the closing edge.
    - Next state is ARMED if commit_req=1 in this cycle, else IDLE.
- Latency:
  - commit_req asserted while vblank is already high: COMMIT in cycle N+1, palette updated at cycle N+2.
  - Otherwise, COMMIT occurs in the first cycle after vblank is sampled high in ARMED.
- Simultaneous events:
  - A write and commit_req in the same cycle (from IDLE): the write lands in shadow and is included in the coming commit.
  - A write presented during COMMIT is stalled (wr_ready=0) and must be held by the master. It is accepted the next cycle and belongs to the next commit.
  - vblank falling while ARMED: no effect, keep waiting for the next blanking.
- Reset mid-operation: state -> IDLE. Shadow and active both return to defaults, and any pending commit is discarded.
- Out-of-range addresses are impossible with a 3-bit address and 8 entries.

Optional Feature:
- Macro: COLORIZER_BLINK_EN.
- Defined:
  - vblank is registered (vblank_q). A rising edge (vblank && !vblank_q) increments a frame counter, which wraps at BLINK_FRAMES-1 and toggles blink_phase.
  - While blink_phase=1, palette entries 5..7 are driven with active entry 0 (background). The stored active values are unchanged.
  - Counter and phase reset to 0.
  - A commit does not disturb the blink phase.
- Not defined: no counter and no phase register; palette = active always.

Test Plan:
- Reset, then hold reset for 3 cycles -> palette = defaults (e0=FFF, e2=F00, e5=0F0); wr_ready=1; armed=0; commit_done=0.
- With vblank=0: write e1=0AB then commit_req -> shadow updated, palette e1 stays 000, armed=1. Raise vblank -> commit_done pulses once on the cycle after vblank is sampled high; e1=0AB on the following cycle.
- With vblank=1: commit_req at cycle N -> commit_done at N+1, wr_ready=0 at N+1, palette updated at N+2. A write held valid at N+1 is accepted at N+2 and does not appear in the palette until a later commit.
- With vblank=0: commit_req, then reset asserted while ARMED -> state IDLE, armed=0. A later vblank produces no commit_done, and palette remains at defaults.
- With COLORIZER_BLINK_EN and BLINK_FRAMES=2: generate 4 vblank rising edges -> entries 5..7 read FFF after edge 2 and 0F0 after edge 4. Entries 0..4 are never altered.
